decode_issue: RTL and testbench

//  Decode/issue stage that sits directly upstream of the execution stage.
//  - Accepts 32-bit instructions from fetch with a valid/ready handshake.
//  - Reads operands from an internal 32x32 register file and drives opcode, dst, src1, src2 and offsetlo into execution.
//  - Implements the pipeline stop for multi-cycle multiply: holds the issued mult stable until it completes.

---
 rtl/decode_issue.sv | 125 ++++++++++++
 tb/tb_decode_issue.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue.sv
// Decode/issue stage: regfile read and issue into execution; `WB_BYPASS_EN adds same-cycle writeback bypass.
// Latency: 1 cycle from accept to ex_*; a mult is held on ex_* for MULT_CYCLES cycles.
// Backpressure: if_ready low while a mult is held; writeback is never stalled.
module decode_issue #(
    parameter int         MULT_CYCLES = 5,
    parameter logic [5:0] MUL_OPCODE  = 6'h02,
    parameter logic [5:0] NOP_OPCODE  = 6'h3F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    output logic        if_ready,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic [5:0]  ex_opcode,
    output logic [4:0]  ex_dst,
    output logic [31:0] ex_src1,
    output logic [31:0] ex_src2,
    output logic [9:0]  ex_offsetlo,
    output logic        ex_valid,
    output logic        busy
);

    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] dst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rsvd;
        logic [9:0] offsetlo;
    } instr_t;

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

    localparam int CW        = (MULT_CYCLES > 2) ? $clog2(MULT_CYCLES - 1) : 1;
    localparam int HOLD_INIT = (MULT_CYCLES > 1) ? MULT_CYCLES - 2 : 0;

    instr_t        instr;
    logic          unused_rsvd;
    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          accept;
    logic [31:0]   rf [32];
    logic [31:0]   rd1, rd2;

    assign instr       = if_instr;
    assign unused_rsvd = instr.rsvd;
    assign accept      = (state == RUN) && if_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (wb_en && (wb_addr != 5'd0)) begin
            rf[wb_addr] <= wb_data;
        end
    end

    always_comb begin
        rd1 = (instr.rs1 == 5'd0) ? 32'd0 : rf[instr.rs1];
        rd2 = (instr.rs2 == 5'd0) ? 32'd0 : rf[instr.rs2];
`ifdef WB_BYPASS_EN
        if (wb_en && (wb_addr != 5'd0) && (wb_addr == instr.rs1)) rd1 = wb_data;
        if (wb_en && (wb_addr != 5'd0) && (wb_addr == instr.rs2)) rd2 = wb_data;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // cnt counts the remaining HOLD cycles after the current one
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            RUN: begin
                if (accept && (instr.opcode == MUL_OPCODE) && (MULT_CYCLES > 1)) begin
                    state_nxt = HOLD;
                    cnt_nxt   = CW'(HOLD_INIT);
                end
            end
            HOLD: begin
                if (cnt == '0) state_nxt = RUN;
                else           cnt_nxt   = cnt - 1'b1;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        if_ready = (state == RUN);
        busy     = (state == HOLD);
    end

    // HOLD leaves every ex_* register untouched; bubbles only retire opcode/valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_opcode   <= NOP_OPCODE;
            ex_dst      <= '0;
            ex_src1     <= '0;
            ex_src2     <= '0;
            ex_offsetlo <= '0;
            ex_valid    <= 1'b0;
        end else if (accept) begin
            ex_opcode   <= instr.opcode;
            ex_dst      <= instr.dst;
            ex_src1     <= rd1;
            ex_src2     <= rd2;
            ex_offsetlo <= instr.offsetlo;
            ex_valid    <= 1'b1;
        end else if (state == RUN) begin
            ex_opcode   <= NOP_OPCODE;
            ex_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: scoreboard of expected ex_* bundles against a bench-side register-file model.
module tb_decode_issue;

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  dst;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [9:0]  off;
        logic        vld;
    } exp_t;

    localparam exp_t RST_EXP = {6'h3F, 80'd0};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_instr;
    logic        if_ready;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [5:0]  ex_opcode;
    logic [4:0]  ex_dst;
    logic [31:0] ex_src1;
    logic [31:0] ex_src2;
    logic [9:0]  ex_offsetlo;
    logic        ex_valid;
    logic        busy;

    exp_t        obs;
    exp_t        sb[$];
    exp_t        last_exp;
    logic [31:0] model_rf [32];
    int          n_checks = 0;
    int          n_pass   = 0;

    decode_issue dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid(if_valid), .if_instr(if_instr), .if_ready(if_ready),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_opcode(ex_opcode), .ex_dst(ex_dst), .ex_src1(ex_src1), .ex_src2(ex_src2),
        .ex_offsetlo(ex_offsetlo), .ex_valid(ex_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    assign obs = {ex_opcode, ex_dst, ex_src1, ex_src2, ex_offsetlo, ex_valid};

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] d,
                                       input logic [4:0] r1, input logic [4:0] r2,
                                       input logic [9:0] off);
        return {op, d, r1, r2, 1'b0, off};
    endfunction

    function automatic exp_t predict(input logic [31:0] ins, input logic we,
                                     input logic [4:0] wa, input logic [31:0] wd);
        exp_t e;
        logic [4:0] r1 = ins[20:16];
        logic [4:0] r2 = ins[15:11];
        e.op  = ins[31:26];
        e.dst = ins[25:21];
        e.s1  = model_rf[r1];
        e.s2  = model_rf[r2];
`ifdef WB_BYPASS_EN
        if (we && wa != 5'd0 && wa == r1) e.s1 = wd;
        if (we && wa != 5'd0 && wa == r2) e.s2 = wd;
`endif
        e.off = ins[9:0];
        e.vld = 1'b1;
        return e;
    endfunction

    // push=1 means the DUT is in RUN for this edge, so an outcome is expected
    task automatic drive_cycle(input logic v, input logic [31:0] ins, input logic push,
                               input logic we, input logic [4:0] wa, input logic [31:0] wd);
        @(negedge clk);
        if_valid = v;
        if_instr = ins;
        wb_en    = we;
        wb_addr  = wa;
        wb_data  = wd;
        if (push) begin
            if (v) begin
                last_exp = predict(ins, we, wa, wd);
            end else begin
                last_exp.op  = 6'h3F;
                last_exp.vld = 1'b0;
            end
            sb.push_back(last_exp);
        end
        @(posedge clk);
        if (we && wa != 5'd0) model_rf[wa] = wd;
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        exp_t tmp;
        drive_cycle(1'b0, 32'd0, 1'b1, 1'b1, a, d);
        tmp = sb.pop_front();
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
        sb.delete();
        last_exp = RST_EXP;
    endtask

    task automatic test_reset();
        exp_t e;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (obs !== RST_EXP) $display("FAIL reset_outputs: got %h want %h", obs, RST_EXP); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        @(negedge clk); rst_n = 1'b1; #1;
        n_checks++; if (if_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", if_ready); else n_pass++;
        drive_cycle(1'b1, mk(6'h05, 5'd1, 5'd0, 5'd0, 10'h055), 1'b1, 1'b0, 5'd0, 32'd0);
        e = sb.pop_front();
        n_checks++; if (obs !== e) $display("FAIL pre_reset_issue: got %h want %h", obs, e); else n_pass++;
        #2; rst_n = 1'b0; if_valid = 1'b0; #1;
        n_checks++; if (obs !== RST_EXP) $display("FAIL reset_midstream: got %h want %h", obs, RST_EXP); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_midstream_busy: got %b want 0", busy); else n_pass++;
        clear_model();
        @(negedge clk); rst_n = 1'b1; #1;
        n_checks++; if (if_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", if_ready); else n_pass++;
    endtask

    task automatic test_add();
        exp_t e;
        drive_cycle(1'b0, 32'd0, 1'b1, 1'b1, 5'd3, 32'd5);
        e = sb.pop_front();
        n_checks++; if (obs !== e) $display("FAIL add_bubble: got %h want %h", obs, e); else n_pass++;
        wr(5'd4, 32'd7);
        drive_cycle(1'b1, mk(6'h00, 5'd5, 5'd3, 5'd4, 10'h012), 1'b1, 1'b0, 5'd0, 32'd0);
        e = sb.pop_front();
        n_checks++; if (obs !== e) $display("FAIL add_issue: got %h want %h", obs, e); else n_pass++;
        n_checks++; if (ex_src1 !== 32'd5 || ex_src2 !== 32'd7)
            $display("FAIL add_operands: got %h/%h want 5/7", ex_src1, ex_src2); else n_pass++;
    endtask

    task automatic test_mult();
        exp_t me, e;
        logic [31:0] nxt = mk(6'h00, 5'd8, 5'd3, 5'd4, 10'h0AB);
        drive_cycle(1'b1, mk(6'h02, 5'd7, 5'd3, 5'd4, 10'h201), 1'b1, 1'b0, 5'd0, 32'd0);
        me = sb.pop_front();
        n_checks++; if (obs !== me) $display("FAIL mult_issue: got %h want %h", obs, me); else n_pass++;
        n_checks++; if (busy !== 1'b1 || if_ready !== 1'b0)
            $display("FAIL mult_hold0: busy %b ready %b want 1 0", busy, if_ready); else n_pass++;
        for (int i = 1; i < 4; i++) begin
            drive_cycle(1'b1, nxt, 1'b0, i == 1, 5'd3, 32'h0000AAAA);
            n_checks++; if (obs !== me) $display("FAIL mult_frozen%0d: got %h want %h", i, obs, me); else n_pass++;
            n_checks++; if (busy !== 1'b1 || if_ready !== 1'b0)
                $display("FAIL mult_hold%0d: busy %b ready %b want 1 0", i, busy, if_ready); else n_pass++;
        end
        drive_cycle(1'b1, nxt, 1'b0, 1'b0, 5'd0, 32'd0);
        n_checks++; if (obs !== me) $display("FAIL mult_frozen4: got %h want %h", obs, me); else n_pass++;
        n_checks++; if (busy !== 1'b0 || if_ready !== 1'b1)
            $display("FAIL mult_release: busy %b ready %b want 0 1", busy, if_ready); else n_pass++;
        drive_cycle(1'b1, nxt, 1'b1, 1'b0, 5'd0, 32'd0);
        e = sb.pop_front();
        n_checks++; if (obs !== e) $display("FAIL mult_next: got %h want %h", obs, e); else n_pass++;
        n_checks++; if (ex_src1 !== 32'h0000AAAA)
            $display("FAIL mult_next_src1: got %h want 0000aaaa", ex_src1); else n_pass++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        drive_cycle(1'b1, mk(6'h15, 5'd12, 5'd4, 5'd3, 10'h3C3), 1'b1, 1'b0, 5'd0, 32'd0);
        e = sb.pop_front();
        n_checks++; if (obs !== e) $display("FAIL b2b_unknown_op: got %h want %h", obs, e); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL b2b_unknown_busy: got %b want 0", busy); else n_pass++;
        drive_cycle(1'b1, mk(6'h3F, 5'd13, 5'd3, 5'd3, 10'h001), 1'b1, 1'b0, 5'd0, 32'd0);
        e = sb.pop_front();
        n_checks++; if (obs !== e) $display("FAIL b2b_second: got %h want %h", obs, e); else n_pass++;
        drive_cycle(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0);
        e = sb.pop_front();
        n_checks++; if (obs !== e) $display("FAIL b2b_bubble: got %h want %h", obs, e); else n_pass++;
    endtask

    task automatic test_r0();
        exp_t e;
        wr(5'd0, 32'h0000DEAD);
        drive_cycle(1'b1, mk(6'h01, 5'd9, 5'd0, 5'd3, 10'h3FF), 1'b1, 1'b0, 5'd0, 32'd0);
        e = sb.pop_front();
        n_checks++; if (obs !== e) $display("FAIL r0_issue: got %h want %h", obs, e); else n_pass++;
        n_checks++; if (ex_src1 !== 32'd0) $display("FAIL r0_src1: got %h want 0", ex_src1); else n_pass++;
    endtask

    task automatic test_bypass();
        exp_t e;
        logic [31:0] want;
`ifdef WB_BYPASS_EN
        want = 32'h00001234;
`else
        want = 32'h00000001;
`endif
        wr(5'd6, 32'h00000001);
        drive_cycle(1'b1, mk(6'h00, 5'd10, 5'd6, 5'd0, 10'h001), 1'b1, 1'b1, 5'd6, 32'h00001234);
        e = sb.pop_front();
        n_checks++; if (obs !== e) $display("FAIL bypass_issue: got %h want %h", obs, e); else n_pass++;
        n_checks++; if (ex_src1 !== want) $display("FAIL bypass_src1: got %h want %h", ex_src1, want); else n_pass++;
        drive_cycle(1'b1, mk(6'h00, 5'd11, 5'd0, 5'd6, 10'h002), 1'b1, 1'b0, 5'd0, 32'd0);
        e = sb.pop_front();
        n_checks++; if (ex_src2 !== 32'h00001234) $display("FAIL bypass_after: got %h want 00001234", ex_src2); else n_pass++;
        n_checks++; if (obs !== e) $display("FAIL bypass_after_issue: got %h want %h", obs, e); else n_pass++;
    endtask

    task automatic test_reset_in_hold();
        exp_t e;
        drive_cycle(1'b1, mk(6'h02, 5'd14, 5'd6, 5'd6, 10'h111), 1'b1, 1'b0, 5'd0, 32'd0);
        e = sb.pop_front();
        n_checks++; if (obs !== e) $display("FAIL hold_rst_issue: got %h want %h", obs, e); else n_pass++;
        drive_cycle(1'b1, mk(6'h00, 5'd15, 5'd0, 5'd0, 10'h000), 1'b0, 1'b0, 5'd0, 32'd0);
        n_checks++; if (busy !== 1'b1) $display("FAIL hold_rst_busy: got %b want 1", busy); else n_pass++;
        #2; rst_n = 1'b0; if_valid = 1'b0; #1;
        n_checks++; if (obs !== RST_EXP) $display("FAIL hold_rst_outputs: got %h want %h", obs, RST_EXP); else n_pass++;
        n_checks++; if (busy !== 1'b0 || if_ready !== 1'b1)
            $display("FAIL hold_rst_state: busy %b ready %b want 0 1", busy, if_ready); else n_pass++;
        clear_model();
        @(negedge clk); rst_n = 1'b1;
        drive_cycle(1'b1, mk(6'h00, 5'd16, 5'd0, 5'd0, 10'h0F0), 1'b1, 1'b0, 5'd0, 32'd0);
        e = sb.pop_front();
        n_checks++; if (obs !== e) $display("FAIL hold_rst_next: got %h want %h", obs, e); else n_pass++;
    endtask

    initial begin
        rst_n    = 1'b0;
        if_valid = 1'b0;
        if_instr = 32'd0;
        wb_en    = 1'b0;
        wb_addr  = 5'd0;
        wb_data  = 32'd0;
        clear_model();
        test_reset();
        test_add();
        test_mult();
        test_back_to_back();
        test_r0();
        test_bypass();
        test_reset_in_hold();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
